// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the memory-stage load/store logic and data_memory_ctrl.
// The master issues requests and consumes responses; the memory controller is the slave.
interface data_memory_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Handshaked data memory with byte-lane writes, one-cycle registered reads,
// out-of-range error responses and an optional zeroing sweep after reset.
module data_memory_ctrl #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int DEPTH          = 1024,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    data_memory_ctrl_if.slave bus,
    output logic              clear_busy
);
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    localparam state_t ST_INIT = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_t             state;
    logic [CNT_W-1:0]   clr_cnt;
    logic               run_en;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [DATA_W-1:0]  rsp_rdata_q;

    logic               req_ready_c;
    logic               accept;
    logic               in_range;
    logic               clr_we;
    logic               wr_en;
    logic [CNT_W-1:0]   idx;

    // run_en is a registered copy of "in RUN", so req_ready stays low while
    // rst_n is held even when no sweep is configured.
    always_comb begin
        req_ready_c = run_en && (!rsp_valid_q || bus.rsp_ready);
        accept      = bus.req_valid && req_ready_c;
        in_range    = {1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH);
        idx         = bus.req_addr[CNT_W-1:0];
        clr_we      = (state == ST_CLEAR);
        wr_en       = accept && bus.req_write && in_range;
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Array has no reset so contents survive rst_n when no sweep is configured.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (bus.req_be[i]) mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            clr_cnt     <= '0;
            run_en      <= 1'b0;
            clear_busy  <= (CLEAR_ON_RESET != 0);
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + CNT_W'(1);
                    if (clr_cnt == CNT_W'(DEPTH - 1)) begin
                        state      <= ST_RUN;
                        clr_cnt    <= '0;
                        clear_busy <= 1'b0;
                        run_en     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    run_en     <= 1'b1;
                    clear_busy <= 1'b0;
                    if (accept) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= !in_range;
                        rsp_rdata_q <= (!bus.req_write && in_range) ? mem[idx] : '0;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed self-checking bench for data_memory_ctrl (DEPTH=16, sweep enabled).
module tb_data_memory_ctrl;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_busy;

    always #5 clk = ~clk;

    data_memory_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    data_memory_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clear_busy(clear_busy)
    );

    typedef struct {
        bit          w;
        logic [15:0] a;
        logic [15:0] d;
        logic [1:0]  be;
        logic [15:0] er;
        bit          ee;
    } vec_t;

    vec_t vt [12];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
    endtask

    task automatic wait_clear(input string name);
        int   n = 0;
        logic rdy_any = 1'b0;
        while (clear_busy && n < 100) begin
            rdy_any |= bus.req_ready;
            step();
            n++;
        end
        chk({name, "_len"}, n, DEPTH);
        chk({name, "_rdy"}, rdy_any, 0);
    endtask

    task automatic do_req(input bit w, input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] be, input logic [15:0] er, input bit ee,
                          input string name);
        int n = 0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_be    = be;
        #1;
        while (!bus.req_ready && n < 20) begin
            step();
            n++;
        end
        chk({name, "_rdy"}, bus.req_ready, 1);
        step();
        idle();
        chk({name, "_vld"}, bus.rsp_valid, 1);
        chk({name, "_rdata"}, bus.rsp_rdata, er);
        chk({name, "_err"}, bus.rsp_err, ee);
    endtask

    initial begin
        vt[0]  = '{1'b1, 16'd5,      16'hBEEF, 2'b11, 16'h0000, 1'b0};
        vt[1]  = '{1'b1, 16'd5,      16'h12AA, 2'b10, 16'h0000, 1'b0};
        vt[2]  = '{1'b0, 16'd5,      16'h0000, 2'b00, 16'h12EF, 1'b0};
        vt[3]  = '{1'b0, 16'd16,     16'h0000, 2'b11, 16'h0000, 1'b1};
        vt[4]  = '{1'b1, 16'hFFFF,   16'h1234, 2'b11, 16'h0000, 1'b1};
        vt[5]  = '{1'b0, 16'd0,      16'h0000, 2'b00, 16'h0000, 1'b0};
        vt[6]  = '{1'b0, 16'd15,     16'h0000, 2'b00, 16'h0000, 1'b0};
        vt[7]  = '{1'b1, 16'd3,      16'hA5A5, 2'b11, 16'h0000, 1'b0};
        vt[8]  = '{1'b1, 16'd7,      16'h77FF, 2'b01, 16'h0000, 1'b0};
        vt[9]  = '{1'b0, 16'd7,      16'h0000, 2'b11, 16'h00FF, 1'b0};
        vt[10] = '{1'b1, 16'd7,      16'h3300, 2'b00, 16'h0000, 1'b0};
        vt[11] = '{1'b0, 16'd7,      16'h0000, 2'b00, 16'h00FF, 1'b0};

        idle();
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err",   bus.rsp_err, 0);
        chk("rst_clear_busy", clear_busy, 1);

        rst_n = 1'b1;
        wait_clear("clear1");

        for (int a = 0; a < DEPTH; a++)
            do_req(1'b0, 16'(a), 16'h0, 2'b00, 16'h0, 1'b0, $sformatf("clrrd%0d", a));

        for (int i = 0; i < 12; i++)
            do_req(vt[i].w, vt[i].a, vt[i].d, vt[i].be, vt[i].er, vt[i].ee,
                   $sformatf("vec%0d", i));

        // Stall: response held for 5 cycles, then handshake and new accept share an edge.
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'd3;
        #1;
        chk("stall_acc_rdy", bus.req_ready, 1);
        step();
        bus.rsp_ready = 1'b0;
        bus.req_addr  = 16'd7;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("stall%0d_vld", i),   bus.rsp_valid, 1);
            chk($sformatf("stall%0d_rdata", i), bus.rsp_rdata, 16'hA5A5);
            chk($sformatf("stall%0d_err", i),   bus.rsp_err, 0);
            chk($sformatf("stall%0d_rdy", i),   bus.req_ready, 0);
            @(posedge clk);
        end
        #1;
        bus.rsp_ready = 1'b1;
        #1;
        chk("release_rdy", bus.req_ready, 1);
        step();
        idle();
        chk("release_vld",   bus.rsp_valid, 1);
        chk("release_rdata", bus.rsp_rdata, 16'h00FF);

        // Stream 8 writes then 8 reads, one per cycle.
        for (int k = 0; k < 16; k++) begin
            bus.req_valid = 1'b1;
            bus.req_write = (k < 8);
            bus.req_addr  = 16'(8 + (k % 8));
            bus.req_wdata = 16'(16'h1000 + 16'h0111 * (k % 8));
            bus.req_be    = 2'b11;
            chk($sformatf("strm%0d_rdy", k), bus.req_ready, 1);
            step();
            chk($sformatf("strm%0d_vld", k), bus.rsp_valid, 1);
            chk($sformatf("strm%0d_rdata", k), bus.rsp_rdata,
                (k < 8) ? 32'h0 : 32'(16'(16'h1000 + 16'h0111 * (k % 8))));
        end
        idle();
        step();

        // Pending response dropped by reset, then reset mid-sweep at counter 7.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'd8;
        #1;
        chk("pend_rdy", bus.req_ready, 1);
        step();
        idle();
        chk("pend_vld", bus.rsp_valid, 1);
        chk("pend_rdata", bus.rsp_rdata, 16'h1000);
        rst_n = 1'b0;
        #1;
        chk("drop_vld", bus.rsp_valid, 0);
        chk("drop_rdata", bus.rsp_rdata, 0);
        chk("drop_busy", clear_busy, 1);
        step();
        rst_n = 1'b1;
        repeat (7) step();
        chk("mid_busy_pre", clear_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", clear_busy, 1);
        chk("mid_rdy", bus.req_ready, 0);
        chk("mid_vld", bus.rsp_valid, 0);
        step();
        rst_n = 1'b1;
        wait_clear("clear2");
        chk("no_replay", bus.rsp_valid, 0);
        do_req(1'b0, 16'd8,  16'h0, 2'b00, 16'h0, 1'b0, "post_rd8");
        do_req(1'b0, 16'd3,  16'h0, 2'b00, 16'h0, 1'b0, "post_rd3");
        do_req(1'b0, 16'd12, 16'h0, 2'b00, 16'h0, 1'b0, "post_rd12");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised, handshaked data memory for the 16-bit processor's load/store path, the successor to the fixed 1024×16 array. It adds valid/ready request and response channels, byte-lane write strobes, a registered read with one-cycle latency, out-of-range address error reporting, and an optional hardware clear sweep after reset. It sits between the memory-stage load/store logic and the backing array.

## Interface
- DATA_W, 16, word width in bits; must be a multiple of 8
- ADDR_W, 16, request address width (word-addressed)
- DEPTH, 1024, number of words; must satisfy DEPTH ≤ 2^ADDR_W
- CLEAR_ON_RESET, 1, when 1 the array is zeroed by a sweep after reset
- clk  in  1  single clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i]
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  address ≥ DEPTH
- clear_busy  out  1  clear sweep in progress

## Operation
- States: CLEAR, RUN. After reset release: CLEAR if CLEAR_ON_RESET=1, else RUN.
- CLEAR: an internal counter walks 0..DEPTH-1, writing all-zero to one word per cycle; clear_busy=1 and req_ready=0. After writing DEPTH-1, go to RUN. The sweep takes exactly DEPTH cycles.
- RUN: req_ready = !rsp_valid || rsp_ready. The request is accepted on a cycle with req_valid && req_ready.
- Accepted write, addr < DEPTH:
  - Each byte lane with req_be[i]=1 is updated; other lanes keep their value.
  - req_be all-zero is a legal no-op.
  - Response: rsp_err=0, rsp_rdata=0.
- Accepted read, addr < DEPTH: rsp_rdata = the array word at the accepting edge, including any write accepted in an earlier cycle. req_be is ignored. rsp_err=0.
- Any accepted request with addr ≥ DEPTH: no array access, rsp_err=1, rsp_rdata=0.
- Every accepted request, read or write, produces exactly one response.
- Response register:
  - Loaded on the accept edge with rsp_valid=1.
  - When rsp_valid && rsp_ready and no new accept occurs, rsp_valid clears.
  - While rsp_valid && !rsp_ready, rsp_rdata and rsp_err are held stable and req_ready=0.
- Array contents are not reset by rst_n unless CLEAR_ON_RESET=1. With CLEAR_ON_RESET=0, contents survive reset.

## Timing
- Reset values (async, while rst_n=0): req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, clear_busy=CLEAR_ON_RESET. State is CLEAR (or RUN) and the clear counter is 0.
- Latency: request accepted at edge N gives rsp_valid=1 after edge N, i.e. one cycle.
- Throughput: one request per cycle while rsp_ready=1. Back-to-back: a response handshake and a new accept can occur on the same edge.
- Read-after-write to the same address on consecutive accepts returns the new data.
- rst_n asserted mid-sweep aborts the sweep. On release, the sweep restarts at address 0.
- rst_n asserted with a response pending drops that response; it is not replayed.
- req_ready is a function of registered state and rsp_ready only. There is no combinational path from req_valid.

## Test plan
- Reset, DEPTH=16, CLEAR_ON_RESET=1 -> clear_busy high for exactly 16 cycles, req_ready=0 throughout; then reads of addresses 0..15 all return 0 with rsp_err=0.
- Write 0xBEEF to addr 5 with be=2'b11, then write 0x12xx to addr 5 with be=2'b10, then read addr 5 -> 0x12EF, one cycle after accept.
- Read addr 16 (DEPTH=16) and write addr 0xFFFF -> each gives rsp_err=1, rsp_rdata=0; no array word changes (spot-check addr 0 and 15).
- Hold rsp_ready=0 for 5 cycles after a read of 0xA5A5 -> rsp_valid, rsp_rdata and rsp_err stable and req_ready=0; on release, the next request is accepted on the same edge as the handshake.
- Stream 8 writes then 8 reads with rsp_ready=1 -> one accept per cycle and the reads return the written data in order.
- Assert rst_n mid-sweep at counter 7 -> outputs go to reset values immediately; after release, clear_busy lasts a full DEPTH cycles.
